// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 matrix keypad scanner.
//   NUM_ROWS/NUM_COLS/NUM_KEYS - matrix geometry
//   kp_state_e                 - debounce FSM encoding
//   key_code_t                 - 4-bit key code, row*4 + col
//   scan_result_t              - result of evaluating one full-matrix snapshot
//   KEY_NONE                   - out-of-range code meaning "no key" (bench use)
//   decode_snapshot()          - single-key detector with ghost rejection
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    // Wider than a key code so it can never collide with a real key.
    localparam logic [4:0] KEY_NONE = 5'b1_0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } kp_state_e;

    typedef logic [3:0] key_code_t;

    typedef struct packed {
        logic      present;
        key_code_t code;
    } scan_result_t;

    // A key is reported only when exactly one bit of the snapshot is set.
    // Two or more closed switches in a passive matrix can create phantom
    // closures, so any multi-key snapshot is treated as no key at all.
    function automatic scan_result_t decode_snapshot(input logic [NUM_KEYS-1:0] snap);
        scan_result_t r;
        int unsigned  n;
        r = '0;
        n = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (snap[i]) begin
                n++;
                r.code = key_code_t'(i);
            end
        end
        r.present = (n == 1);
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: parameterized-width two-flop synchronizer for asynchronous
// board inputs. Resets to all-ones, which is the idle level of pulled-up,
// active-low inputs such as keypad columns.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronized output (two clk cycles of latency)
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 passive matrix keypad and delivers debounced
// key events with a valid/ack handshake (one event per press, no repeat).
//   clk       - system clock
//   rst_n     - asynchronous active-low reset (synchronous release upstream)
//   rows      - row drive, active-low, exactly one bit low at any time
//   cols      - column sense, active-low, asynchronous to clk
//   key_code  - accepted key, row*4 + col
//   key_valid - event pending, held until key_ack
//   key_ack   - consumer accepts the pending event (pulse or level)
//   key_down  - level: a debounced key is currently held
//   overrun   - sticky: a press was accepted while key_valid was still high
import keypad_pkg::*;

module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] rows,
    input  logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    // One extra count of headroom so DEBOUNCE_SCANS itself is representable,
    // including the DEBOUNCE_SCANS==1 case.
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    // ------------------------------------------------------------------
    // Column synchronizer
    // ------------------------------------------------------------------
    logic [NUM_COLS-1:0] cols_s;

    sync_2ff #(.WIDTH(NUM_COLS)) u_cols_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cols),
        .q     (cols_s)
    );

    // ------------------------------------------------------------------
    // Row scan: each row is driven for SCAN_DIV cycles; its columns are
    // sampled on the last cycle, giving the pull-ups and the synchronizer
    // time to settle after the row change.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]    div;
    logic [1:0]          row_idx;
    logic [1:0]          row_nxt;
    logic                tick;
    logic                scan_end;
    logic [NUM_KEYS-1:0] snapshot;
    logic [NUM_KEYS-1:0] snap_nxt;
    scan_result_t        res;

    assign tick     = (div == DIV_LAST);
    assign scan_end = tick && (row_idx == 2'd3);
    assign row_nxt  = row_idx + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div     <= '0;
            row_idx <= 2'd0;
            rows    <= 4'b1110;
        end else if (tick) begin
            div     <= '0;
            row_idx <= row_nxt;
            rows    <= ~(4'b0001 << row_nxt);
        end else begin
            div     <= div + DIV_W'(1);
        end
    end

    // The scan-end evaluation looks at the snapshot including the row-3
    // columns captured on that same edge, so a scan is judged on data that
    // is all from the scan just completed.
    always_comb begin
        snap_nxt = snapshot;
        if (tick) begin
            snap_nxt[row_idx*NUM_COLS +: NUM_COLS] = ~cols_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) snapshot <= '0;
        else        snapshot <= snap_nxt;
    end

    assign res = decode_snapshot(snap_nxt);

    // ------------------------------------------------------------------
    // Debounce FSM, advanced once per completed scan
    // ------------------------------------------------------------------
    kp_state_e  state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    key_code_t  cand, cand_nxt;
    logic       same;
    logic       accept;
    logic       release_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cand  <= cand_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cand_nxt     = cand;
        accept       = 1'b0;
        release_done = 1'b0;
        cnt_inc      = cnt + CNT_W'(1);
        same         = res.present && (res.code == cand);

        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (res.present) begin
                        cand_nxt = res.code;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept    = 1'b1;
                            state_nxt = HELD;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = PRESS_DB;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                PRESS_DB: begin
                    if (same) begin
                        if (cnt_inc == CNT_DONE) begin
                            accept    = 1'b1;
                            state_nxt = HELD;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt   = cnt_inc;
                        end
                    end else begin
                        // Release, a different key or a multi-key scan
                        // aborts the press without an event.
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                HELD: begin
                    if (same) begin
                        cnt_nxt = '0;
                    end else if (DEBOUNCE_SCANS == 1) begin
                        state_nxt    = IDLE;
                        cnt_nxt      = '0;
                        release_done = 1'b1;
                    end else begin
                        state_nxt = REL_DB;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                REL_DB: begin
                    if (same) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else if (cnt_inc == CNT_DONE) begin
                        state_nxt    = IDLE;
                        cnt_nxt      = '0;
                        release_done = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Event outputs and handshake. An accept on the same edge as an ack
    // re-arms key_valid with the new key; the old event counts as taken,
    // so that case is not an overrun.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (accept) begin
                key_code  <= cand_nxt;
                key_valid <= 1'b1;
                if (key_valid && !key_ack) overrun <= 1'b1;
            end else if (key_ack) begin
                key_valid <= 1'b0;
            end

            if (accept)            key_down <= 1'b1;
            else if (release_done) key_down <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and randomized checks of keypad_scanner with
// SCAN_DIV=4, DEBOUNCE_SCANS=2 (one scan = 16 cycles). A switch-matrix model
// drives cols from rows; a scan-level behavioural model predicts events.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 2;
    localparam int SCAN     = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        key_down;
    logic        overrun;
    logic [15:0] pressed;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rows      (rows),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_down  (key_down),
        .overrun   (overrun)
    );

    // Passive matrix: a closed switch pulls its column low when its row is driven low.
    always_comb begin
        cols = 4'b1111;
        for (int r = 0; r < 4; r++)
            if (!rows[r])
                for (int c = 0; c < 4; c++)
                    if (pressed[r*4+c]) cols[c] = 1'b0;
    end

    // Counts debounced presses (rising edges of key_down).
    int   rises = 0;
    logic down_q = 1'b0;
    always @(posedge clk) begin
        if (key_down && !down_q) rises <= rises + 1;
        down_q <= key_down;
    end

    // ---------------- behavioural model (one step per full scan) -------------
    bit m_valid, m_down, m_ovr;
    int m_code, m_cand, m_run;

    task automatic model_reset();
        m_valid = 0; m_down = 0; m_ovr = 0;
        m_code = 0; m_cand = 0; m_run = 0;
    endtask

    function automatic int scan_key(input logic [15:0] k);
        if ($countones(k) != 1) return -1;
        for (int i = 0; i < 16; i++) if (k[i]) return i;
        return -1;
    endfunction

    // r: the single key seen this scan, or -1 for none / several.
    task automatic model_scan(input int r, input bit ack_at_end);
        bit acc;
        acc = 0;
        if (!m_down) begin
            if (r >= 0 && m_run > 0 && r == m_cand) m_run++;
            else if (r >= 0 && m_run == 0) begin m_cand = r; m_run = 1; end
            else m_run = 0;
            if (m_run == DB) begin acc = 1; m_run = 0; m_down = 1; end
        end else begin
            if (r == m_cand) m_run = 0;
            else begin
                m_run++;
                if (m_run == DB) begin m_down = 0; m_run = 0; end
            end
        end
        if (acc) begin
            if (m_valid && !ack_at_end) m_ovr = 1;
            m_valid = 1;
            m_code  = m_cand;
        end else if (ack_at_end) begin
            m_valid = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_valid"}, 32'(key_valid), 32'(m_valid));
        chk({tag, "_code"},  32'(key_code),  32'(m_code));
        chk({tag, "_down"},  32'(key_down),  32'(m_down));
        chk({tag, "_ovr"},   32'(overrun),   32'(m_ovr));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rows"},  32'(rows),      32'h0000_000e);
        chk({tag, "_valid"}, 32'(key_valid), 32'h0);
        chk({tag, "_code"},  32'(key_code),  32'h0);
        chk({tag, "_down"},  32'(key_down),  32'h0);
        chk({tag, "_ovr"},   32'(overrun),   32'h0);
    endtask

    // Leaves the bench just after the releasing negedge: the 16th posedge
    // from here is the first scan end.
    task automatic do_reset();
        key_ack = 1'b0;
        pressed = '0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Rows must step every SCAN_DIV cycles starting from row 0.
    task automatic rows_phase(input int ncyc, input string tag);
        logic [3:0] exp_rows;
        for (int p = 1; p <= ncyc; p++) begin
            @(posedge clk);
            #1;
            exp_rows = 4'b1111 ^ (4'b0001 << ((p / SCAN_DIV) % 4));
            chk({tag, "_rows"}, 32'(rows), 32'(exp_rows));
            if (p % SCAN_DIV == 0) begin
                chk({tag, "_valid"}, 32'(key_valid), 32'h0);
                chk({tag, "_down"},  32'(key_down),  32'h0);
            end
        end
    endtask

    // One full scan with a stable key pattern; optional ack mid-scan and on
    // the scan-end edge itself. Starts and ends 1 time unit after a scan end.
    task automatic run_scan(input logic [15:0] keys, input bit mid_ack, input bit end_ack,
                            input string tag);
        pressed = keys;
        repeat (7) @(posedge clk);
        #1;
        key_ack = mid_ack;
        @(posedge clk);
        #1;
        key_ack = 1'b0;
        if (mid_ack) m_valid = 0;
        repeat (7) @(posedge clk);
        #1;
        key_ack = end_ack;
        @(posedge clk);
        #1;
        key_ack = 1'b0;
        model_scan(scan_key(keys), end_ack);
        chk_model(tag);
    endtask

    function automatic logic [15:0] kbit(input int k);
        logic [15:0] one;
        one = 16'h0001;
        return one << k;
    endfunction

    initial begin
        int base;
        logic [15:0] keys;
        int k1, k2, sel, ns;

        rst_n   = 1'b0;
        key_ack = 1'b0;
        pressed = '0;

        // Idle scanning, no keys
        do_reset();
        rows_phase(200, "idle");

        // Single press row2/col1 -> code 9, ack, still held
        do_reset();
        for (int i = 0; i < 3; i++) run_scan(kbit(9), 0, 0, "p9");
        chk("p9_valid_now", 32'(key_valid), 32'h1);
        chk("p9_code_now",  32'(key_code),  32'h9);
        run_scan(kbit(9), 1, 0, "p9_ack");
        chk("p9_acked", 32'(key_valid), 32'h0);
        chk("p9_held",  32'(key_down),  32'h1);
        for (int i = 0; i < 3; i++) run_scan(kbit(9), 0, 0, "p9_hold");

        // Bouncing row0/col0, then held, then released
        do_reset();
        base = rises;
        for (int i = 0; i < 7; i++) begin
            pressed[0] = ~pressed[0];
            repeat (3) @(posedge clk);
        end
        #1;
        pressed[0] = 1'b1;
        repeat (4 * SCAN) @(posedge clk);
        #1;
        chk("bnc_valid",  32'(key_valid),  32'h1);
        chk("bnc_code",   32'(key_code),   32'h0);
        chk("bnc_down",   32'(key_down),   32'h1);
        chk("bnc_events", 32'(rises - base), 32'h1);
        chk("bnc_ovr",    32'(overrun),    32'h0);
        pressed = '0;
        repeat (4 * SCAN) @(posedge clk);
        #1;
        chk("bnc_rel_down",   32'(key_down),     32'h0);
        chk("bnc_rel_events", 32'(rises - base), 32'h1);
        chk("bnc_rel_ovr",    32'(overrun),      32'h0);

        // Ghost rejection: 6 and 15 together, then 15 released
        do_reset();
        for (int i = 0; i < 3; i++) run_scan(kbit(6) | kbit(15), 0, 0, "ghost");
        chk("ghost_none", 32'(key_valid), 32'h0);
        for (int i = 0; i < 2; i++) run_scan(kbit(6), 0, 0, "ghost_rel");
        chk("ghost_code", 32'(key_code), 32'h6);

        // Overrun: 5 unacked, release, 12
        do_reset();
        for (int i = 0; i < 3; i++) run_scan(kbit(5), 0, 0, "ov5");
        for (int i = 0; i < 3; i++) run_scan('0, 0, 0, "ov_rel");
        for (int i = 0; i < 2; i++) run_scan(kbit(12), 0, 0, "ov12");
        chk("ov_code",  32'(key_code),  32'hc);
        chk("ov_valid", 32'(key_valid), 32'h1);
        chk("ov_flag",  32'(overrun),   32'h1);
        run_scan(kbit(12), 1, 0, "ov_ack");
        chk("ov_ack_valid", 32'(key_valid), 32'h0);
        chk("ov_sticky",    32'(overrun),   32'h1);

        // Accept on the same edge as ack: accept wins, no overrun
        do_reset();
        for (int i = 0; i < 2; i++) run_scan(kbit(3), 0, 0, "aa3");
        for (int i = 0; i < 3; i++) run_scan('0, 0, 0, "aa_rel");
        run_scan(kbit(7), 0, 0, "aa7a");
        run_scan(kbit(7), 0, 1, "aa7b");
        chk("aa_valid", 32'(key_valid), 32'h1);
        chk("aa_code",  32'(key_code),  32'h7);
        chk("aa_ovr",   32'(overrun),   32'h0);

        // Reset mid-scan with an event pending
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        pressed = '0;
        rows_phase(32, "restart");

        // Randomized key patterns against the model
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            sel = $urandom_range(0, 9);
            k1  = $urandom_range(0, 15);
            k2  = (k1 + $urandom_range(1, 15)) % 16;
            if (sel < 4)      keys = '0;
            else if (sel < 8) keys = kbit(k1);
            else              keys = kbit(k1) | kbit(k2);
            ns = $urandom_range(1, 4);
            for (int s = 0; s < ns; s++)
                run_scan(keys, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
